// File: rtl/aspiradora_pkg.sv
// Shared types and helpers for the robot-vacuum controller.
// State encoding is visible on the top-level state port.
package aspiradora_pkg;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        IDLE   = 3'd1,
        CLEAN  = 3'd2,
        EVADE  = 3'd3,
        RETURN = 3'd4,
        CHARGE = 3'd5
    } state_t;

    // States in which the wheels run and the battery drains.
    function automatic logic is_drain(input state_t s);
        return (s == CLEAN) || (s == EVADE) || (s == RETURN);
    endfunction

endpackage

// File: rtl/aspiradora_batt.sv
// Battery model: prescaler plus saturating up/down level counter.
// One level step per DRAIN_DIV (drain) or CHARGE_DIV (charge) cycles.
import aspiradora_pkg::*;

module aspiradora_batt #(
    parameter int BATT_W     = 4,
    parameter int BATT_MAX   = 15,
    parameter int DRAIN_DIV  = 8,
    parameter int CHARGE_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain,
    input  logic              charge,
    input  logic              clr_presc,
    output logic [BATT_W-1:0] level
);

    localparam int DIV_MAX = (DRAIN_DIV > CHARGE_DIV) ? DRAIN_DIV : CHARGE_DIV;
    localparam int PW      = $clog2(DIV_MAX + 1);

    localparam logic [PW-1:0]     DRAIN_TOP  = PW'(DRAIN_DIV - 1);
    localparam logic [PW-1:0]     CHARGE_TOP = PW'(CHARGE_DIV - 1);
    localparam logic [BATT_W-1:0] FULL       = BATT_W'(BATT_MAX);

    logic [PW-1:0] presc;
    logic          wrap_dn;
    logic          wrap_up;

    // Prescaler wrap points for the current activity.
    always_comb begin
        wrap_dn = drain && (presc == DRAIN_TOP);
        wrap_up = charge && (presc == CHARGE_TOP);
    end

    // Prescaler restarts on wrap, on state change, or when idle;
    // the level update on a wrap still lands on a transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            level <= FULL;
        end else begin
            if (clr_presc || wrap_dn || wrap_up || !(drain || charge))
                presc <= '0;
            else
                presc <= presc + 1'b1;

            if (wrap_dn && level != '0)
                level <= level - 1'b1;
            else if (wrap_up && level != FULL)
                level <= level + 1'b1;
        end
    end

endmodule

// File: rtl/aspiradora_ctrl.sv
// Robot-vacuum Moore FSM: cleaning, timed obstacle evasion,
// low-battery return to dock and charging.
import aspiradora_pkg::*;

module aspiradora_ctrl #(
    parameter int EVADE_CYCLES = 16,
    parameter int BATT_W       = 4,
    parameter int BATT_MAX     = 15,
    parameter int BATT_LOW     = 3,
    parameter int DRAIN_DIV    = 8,
    parameter int CHARGE_DIV   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_off,
    input  logic              on,
    input  logic              clean_req,
    input  logic              obstacle,
    input  logic              dock_present,
    output logic [2:0]        state,
    output logic [BATT_W-1:0] batt_level,
    output logic              low_batt,
    output logic              motor_en,
    output logic              brush_en
);

    localparam int TW = $clog2(EVADE_CYCLES + 1);

    localparam logic [TW-1:0]     T_LAST = TW'(EVADE_CYCLES - 1);
    localparam logic [BATT_W-1:0] B_LOW  = BATT_W'(BATT_LOW);
    localparam logic [BATT_W-1:0] B_FULL = BATT_W'(BATT_MAX);

    state_t            state_q;
    state_t            state_d;
    logic [TW-1:0]     timer_q;
    logic [TW-1:0]     timer_d;
    logic [BATT_W-1:0] batt;
    logic              low;
    logic              empty;

    assign low   = (batt <= B_LOW);
    assign empty = (batt == '0);

    // Next-state decision, always on the pre-update battery level.
    always_comb begin
        state_d = state_q;
        if (power_off) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF: begin
                    if (on) state_d = IDLE;
                end
                IDLE: begin
                    if (clean_req && !low)
                        state_d = CLEAN;
                    else if (dock_present && batt < B_FULL)
                        state_d = CHARGE;
                end
                CLEAN: begin
                    if (empty)           state_d = OFF;
                    else if (obstacle)   state_d = EVADE;
                    else if (low)        state_d = RETURN;
                    else if (!clean_req) state_d = IDLE;
                end
                EVADE: begin
                    if (empty)
                        state_d = OFF;
                    else if (!obstacle && timer_q == T_LAST)
                        state_d = low ? RETURN : CLEAN;
                end
                RETURN: begin
                    if (empty)             state_d = OFF;
                    else if (dock_present) state_d = CHARGE;
                end
                CHARGE: begin
                    if (!dock_present)        state_d = IDLE;
                    else if (batt == B_FULL)  state_d = IDLE;
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Evade timer runs only while staying in EVADE; a new bump restarts it.
    always_comb begin
        timer_d = '0;
        if (state_q == EVADE && state_d == EVADE && !obstacle)
            timer_d = timer_q + 1'b1;
    end

    // State and evade-timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    aspiradora_batt #(
        .BATT_W     (BATT_W),
        .BATT_MAX   (BATT_MAX),
        .DRAIN_DIV  (DRAIN_DIV),
        .CHARGE_DIV (CHARGE_DIV)
    ) u_batt (
        .clk       (clk),
        .rst       (rst),
        .drain     (is_drain(state_q)),
        .charge    (state_q == CHARGE),
        .clr_presc (state_d != state_q),
        .level     (batt)
    );

    assign state      = state_q;
    assign batt_level = batt;
    assign low_batt   = low;
    assign motor_en   = is_drain(state_q);
    assign brush_en   = (state_q == CLEAN);

endmodule

// File: tb/tb_aspiradora_ctrl.sv
// Bench for aspiradora_ctrl: vector table, directed corner sequences
// and random stimulus against a cycle-level reference model.
import aspiradora_pkg::*;

module tb_aspiradora_ctrl;

    localparam int EC   = 4;
    localparam int BW   = 4;
    localparam int BMAX = 8;
    localparam int BLOW = 2;
    localparam int DD   = 2;
    localparam int CD   = 3;

    typedef struct {
        logic [5:0] ins;
        state_t     st;
        logic [3:0] batt;
        logic [2:0] flags;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic power_off = 1'b0;
    logic on = 1'b0;
    logic clean_req = 1'b0;
    logic obstacle = 1'b0;
    logic dock_present = 1'b0;

    logic [2:0]    state;
    logic [BW-1:0] batt_level;
    logic          low_batt;
    logic          motor_en;
    logic          brush_en;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl [20];

    state_t m_st    = OFF;
    int     m_batt  = BMAX;
    int     m_ticks = 0;
    int     m_left  = EC;

    aspiradora_ctrl #(
        .EVADE_CYCLES (EC),
        .BATT_W       (BW),
        .BATT_MAX     (BMAX),
        .BATT_LOW     (BLOW),
        .DRAIN_DIV    (DD),
        .CHARGE_DIV   (CD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .power_off    (power_off),
        .on           (on),
        .clean_req    (clean_req),
        .obstacle     (obstacle),
        .dock_present (dock_present),
        .state        (state),
        .batt_level   (batt_level),
        .low_batt     (low_batt),
        .motor_en     (motor_en),
        .brush_en     (brush_en)
    );

    always #5 clk = ~clk;

    // Reference: counts elapsed cycles per activity and remaining evade dwell.
    always @(posedge clk) begin : ref_model
        state_t nst;
        int     nb;
        int     nt;
        int     nl;
        nst = m_st;
        nb  = m_batt;
        nt  = m_ticks;
        nl  = m_left;
        if (rst) begin
            nst = OFF;
            nb  = BMAX;
            nt  = 0;
            nl  = EC;
        end else begin
            if (power_off) begin
                nst = OFF;
            end else begin
                case (m_st)
                    OFF:    if (on) nst = IDLE;
                    IDLE:   if (clean_req && m_batt > BLOW) nst = CLEAN;
                            else if (dock_present && m_batt < BMAX) nst = CHARGE;
                    CLEAN:  if (m_batt == 0) nst = OFF;
                            else if (obstacle) nst = EVADE;
                            else if (m_batt <= BLOW) nst = RETURN;
                            else if (!clean_req) nst = IDLE;
                    EVADE:  if (m_batt == 0) nst = OFF;
                            else if (!obstacle && m_left == 1)
                                nst = (m_batt <= BLOW) ? RETURN : CLEAN;
                    RETURN: if (m_batt == 0) nst = OFF;
                            else if (dock_present) nst = CHARGE;
                    CHARGE: if (!dock_present || m_batt == BMAX) nst = IDLE;
                    default: nst = OFF;
                endcase
            end
            if (m_st == CLEAN || m_st == EVADE || m_st == RETURN) begin
                nt++;
                if (nt == DD) begin
                    nt = 0;
                    if (nb > 0) nb--;
                end
            end else if (m_st == CHARGE) begin
                nt++;
                if (nt == CD) begin
                    nt = 0;
                    if (nb < BMAX) nb++;
                end
            end else begin
                nt = 0;
            end
            if (nst != m_st) nt = 0;
            if (nst == EVADE)
                nl = (m_st != EVADE || obstacle) ? EC : nl - 1;
        end
        m_st    <= nst;
        m_batt  <= nb;
        m_ticks <= nt;
        m_left  <= nl;
    end

    function automatic vec_t mkv(input logic [5:0] i, input state_t s,
                                 input logic [3:0] b, input logic [2:0] f);
        vec_t v;
        v.ins   = i;
        v.st    = s;
        v.batt  = b;
        v.flags = f;
        return v;
    endfunction

    // {low_batt, motor_en, brush_en} implied by a state and level.
    function automatic logic [2:0] exp_flags(input state_t s, input int b);
        logic lo;
        logic mo;
        logic br;
        lo = (b <= BLOW);
        mo = (s == CLEAN) || (s == EVADE) || (s == RETURN);
        br = (s == CLEAN);
        return {lo, mo, br};
    endfunction

    task automatic check(input string tag, input state_t es, input int eb,
                         input logic [2:0] ef);
        n_vec++;
        if (state !== es || batt_level !== BW'(eb) ||
            {low_batt, motor_en, brush_en} !== ef) begin
            n_bad++;
            $display("FAIL %s: got state=%0d batt=%0d low/mot/br=%b, want state=%0d batt=%0d low/mot/br=%b",
                     tag, state, batt_level, {low_batt, motor_en, brush_en},
                     es, eb, ef);
        end
    endtask

    task automatic chk(input string tag, input state_t es, input int eb);
        check(tag, es, eb, exp_flags(es, eb));
    endtask

    // Input order: {rst, power_off, on, clean_req, obstacle, dock_present}.
    task automatic drive(input logic [5:0] v);
        {rst, power_off, on, clean_req, obstacle, dock_present} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_clean(input string tag);
        drive(6'b100000); tick(); chk({tag, ".rst"}, OFF, BMAX);
        drive(6'b001000); tick(); chk({tag, ".on"}, IDLE, BMAX);
        drive(6'b000100); tick(); chk({tag, ".clean"}, CLEAN, BMAX);
    endtask

    task automatic drain_clean(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            chk({tag, ".drain"}, CLEAN, BMAX - k / 2);
        end
    endtask

    initial begin
        tbl[0]  = mkv(6'b100000, OFF,    4'd8, 3'b000);
        tbl[1]  = mkv(6'b001000, IDLE,   4'd8, 3'b000);
        tbl[2]  = mkv(6'b000000, IDLE,   4'd8, 3'b000);
        tbl[3]  = mkv(6'b000100, CLEAN,  4'd8, 3'b011);
        tbl[4]  = mkv(6'b000100, CLEAN,  4'd8, 3'b011);
        tbl[5]  = mkv(6'b000110, EVADE,  4'd7, 3'b010);
        tbl[6]  = mkv(6'b000100, EVADE,  4'd7, 3'b010);
        tbl[7]  = mkv(6'b000100, EVADE,  4'd6, 3'b010);
        tbl[8]  = mkv(6'b000100, EVADE,  4'd6, 3'b010);
        tbl[9]  = mkv(6'b000100, CLEAN,  4'd5, 3'b011);
        tbl[10] = mkv(6'b000110, EVADE,  4'd5, 3'b010);
        tbl[11] = mkv(6'b000100, EVADE,  4'd5, 3'b010);
        tbl[12] = mkv(6'b000110, EVADE,  4'd4, 3'b010);
        tbl[13] = mkv(6'b000100, EVADE,  4'd4, 3'b010);
        tbl[14] = mkv(6'b000100, EVADE,  4'd3, 3'b010);
        tbl[15] = mkv(6'b000100, EVADE,  4'd3, 3'b010);
        tbl[16] = mkv(6'b000100, CLEAN,  4'd2, 3'b111);
        tbl[17] = mkv(6'b000100, RETURN, 4'd2, 3'b110);
        tbl[18] = mkv(6'b000000, RETURN, 4'd2, 3'b110);
        tbl[19] = mkv(6'b000001, CHARGE, 4'd1, 3'b100);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].ins);
            tick();
            check($sformatf("row%0d", i), tbl[i].st, int'(tbl[i].batt),
                  tbl[i].flags);
        end

        // Full drain to RETURN, then charge back to full.
        start_clean("A");
        drain_clean("A", 12);
        tick(); chk("A.ret", RETURN, 2);
        drive(6'b000001); tick(); chk("A.dock", CHARGE, 2);
        for (int j = 1; j <= 18; j++) begin
            tick();
            chk("A.chg", CHARGE, 2 + j / 3);
        end
        tick(); chk("A.full", IDLE, BMAX);

        // Undock mid-charge, then resume cleaning.
        start_clean("B");
        drain_clean("B", 10);
        drive(6'b000000); tick(); chk("B.idle", IDLE, 3);
        drive(6'b000001); tick(); chk("B.dock", CHARGE, 3);
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("B.chg", CHARGE, 3 + j / 3);
        end
        drive(6'b000000); tick(); chk("B.undock", IDLE, 5);
        tick(); chk("B.hold", IDLE, 5);
        drive(6'b000100); tick(); chk("B.clean", CLEAN, 5);

        // power_off beats obstacle in EVADE; level survives OFF.
        drive(6'b000010); tick(); chk("C.evade", EVADE, 5);
        drive(6'b010010); tick(); chk("C.off", OFF, 5);
        drive(6'b001000); tick(); chk("C.on", IDLE, 5);

        // Reset while charging.
        start_clean("D");
        drain_clean("D", 8);
        drive(6'b000000); tick(); chk("D.idle", IDLE, 4);
        drive(6'b000001); tick(); chk("D.dock", CHARGE, 4);
        tick(); chk("D.chg", CHARGE, 4);
        drive(6'b100001); tick(); chk("D.rst", OFF, BMAX);
        drive(6'b001001); tick(); chk("D.on", IDLE, BMAX);
        tick(); chk("D.full", IDLE, BMAX);
        drive(6'b000100); tick(); chk("D.clean", CLEAN, BMAX);
        tick(); chk("D.c1", CLEAN, BMAX);
        tick(); chk("D.c2", CLEAN, BMAX - 1);

        // RETURN runs dry before docking; obstacle ignored.
        start_clean("E");
        drain_clean("E", 12);
        tick(); chk("E.ret", RETURN, 2);
        drive(6'b000010);
        for (int r = 1; r <= 4; r++) begin
            tick();
            chk("E.ret", RETURN, 2 - r / 2);
        end
        tick(); chk("E.dead", OFF, 0);

        // Random traffic against the reference model.
        drive(6'b100000);
        tick();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(63) == 0);
            power_off = ($urandom_range(31) == 0);
            on        = ($urandom_range(3) == 0);
            clean_req = ($urandom_range(3) != 0);
            obstacle  = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0)
                dock_present = ~dock_present;
            tick();
            chk($sformatf("rand%0d", i), m_st, m_batt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
